multicycle_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle RV32I control unit: one FSM sequences every instruction through fetch, decode, execute, memory and writeback over several cycles.
- Memory accesses use a mem_ready handshake, so the datapath can share one variable-latency memory port.
- The ALU decode is built in and parametrised for an extended operation set.
- Sits between the instruction register and the multi-cycle datapath: IR, OldPC, A/B and ALUOut registers.

---
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing with a
// mem_ready handshake on the shared memory port and built-in ALU decode (optional extended ops).
module multicycle_control_unit #(
  parameter int EXT_ALU   = 0,
  parameter int ALUCTRL_W = 3 + EXT_ALU
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           Op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 RegWrite,
  output logic                 illegal,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t     state, next_state;
  logic [1:0] alu_op;
  logic [3:0] alu_full;
  logic       funct_ok;
  logic       unused_bits;

  assign unused_bits = ^{funct7[6], funct7[4:0], alu_full[3]};

  // sltu is never supported; xor/sll/srl/sra only exist with the extended decode
  assign funct_ok = (funct3 != 3'b011) &&
                    ((EXT_ALU != 0) ||
                     !((funct3 == 3'b100) || (funct3 == 3'b001) || (funct3 == 3'b101)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    alu_op     = 2'b00;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    RegWrite   = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = funct_ok ? S_EXECR : S_TRAP;
          OP_ITYPE:          next_state = funct_ok ? S_EXECI : S_TRAP;
          OP_BRANCH:         next_state = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            next_state = S_JAL;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        PCWrite = funct3[0] ? ~Zero : Zero;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = 2'b11;
        ALUSrcB    = 2'b01;
        next_state = S_ALUWB;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    case (Op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // Base codes live in the low 3 bits so the narrow configuration is a plain truncation
  always_comb begin
    alu_full = 4'b0000;
    case (alu_op)
      2'b01: alu_full = 4'b0001;
      2'b10: begin
        case (funct3)
          3'b000: alu_full = (Op[5] & funct7[5]) ? 4'b0001 : 4'b0000;
          3'b010: alu_full = 4'b0101;
          3'b110: alu_full = 4'b0011;
          3'b111: alu_full = 4'b0010;
          3'b100: if (EXT_ALU != 0) alu_full = 4'b0100;
          3'b001: if (EXT_ALU != 0) alu_full = 4'b0110;
          3'b101: if (EXT_ALU != 0) alu_full = funct7[5] ? 4'b1000 : 4'b0111;
          default: alu_full = 4'b0000;
        endcase
      end
      default: alu_full = 4'b0000;
    endcase
  end

  assign ALUControl = alu_full[ALUCTRL_W-1:0];
  assign illegal    = (state == S_TRAP);
  assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for both ALU configurations side by side, checked each cycle against a path-level model.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       regw;
    logic       ill;
    logic [3:0] st;
  } outs_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, JR = 7'b1100111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] Op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write [2];
  logic       adr_src [2];
  logic       mem_write [2];
  logic       ir_write [2];
  logic [1:0] result_src [2];
  logic [1:0] alu_src_a [2];
  logic [1:0] alu_src_b [2];
  logic [2:0] imm_src [2];
  logic       reg_write [2];
  logic       illegal [2];
  logic [3:0] state_o [2];
  logic [2:0] alu_c0;
  logic [3:0] alu_c1;
  outs_t      got [2];

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  int e_st [2];
  int tr0[$], tr1[$];
  logic mrq[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(.EXT_ALU(0)) dut0 (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(pc_write[0]), .AdrSrc(adr_src[0]), .MemWrite(mem_write[0]),
    .IRWrite(ir_write[0]), .ResultSrc(result_src[0]), .ALUSrcA(alu_src_a[0]),
    .ALUSrcB(alu_src_b[0]), .ImmSrc(imm_src[0]), .ALUControl(alu_c0), .RegWrite(reg_write[0]),
    .illegal(illegal[0]), .state_o(state_o[0])
  );

  multicycle_control_unit #(.EXT_ALU(1)) dut1 (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(pc_write[1]), .AdrSrc(adr_src[1]), .MemWrite(mem_write[1]),
    .IRWrite(ir_write[1]), .ResultSrc(result_src[1]), .ALUSrcA(alu_src_a[1]),
    .ALUSrcB(alu_src_b[1]), .ImmSrc(imm_src[1]), .ALUControl(alu_c1), .RegWrite(reg_write[1]),
    .illegal(illegal[1]), .state_o(state_o[1])
  );

  assign got[0] = {pc_write[0], adr_src[0], mem_write[0], ir_write[0], result_src[0],
                   alu_src_a[0], alu_src_b[0], imm_src[0], {1'b0, alu_c0}, reg_write[0],
                   illegal[0], state_o[0]};
  assign got[1] = {pc_write[1], adr_src[1], mem_write[1], ir_write[1], result_src[1],
                   alu_src_a[1], alu_src_b[1], imm_src[1], alu_c1, reg_write[1],
                   illegal[1], state_o[1]};

  // Instruction class: 0 trap, 1 lw, 2 sw, 3 R, 4 I, 5 branch, 6 jal, 7 lui
  function automatic int kind(input logic [6:0] op, input logic [2:0] f3, input int ext);
    bit ext_only = (f3 == 3'd4) || (f3 == 3'd1) || (f3 == 3'd5);
    if (op == LW) return 1;
    if (op == SW) return 2;
    if (op == RT || op == IT) begin
      if (f3 == 3'd3 || (ext == 0 && ext_only)) return 0;
      return (op == RT) ? 3 : 4;
    end
    if (op == BR) return (f3 <= 3'd1) ? 5 : 0;
    if (op == JL) return 6;
    if (op == LU) return 7;
    return 0;
  endfunction

  function automatic logic [3:0] m_funct(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7, input int ext);
    case (f3)
      3'd0: return (op[5] && f7[5]) ? 4'd1 : 4'd0;
      3'd2: return 4'd5;
      3'd6: return 4'd3;
      3'd7: return 4'd2;
      3'd4: return (ext != 0) ? 4'd4 : 4'd0;
      3'd1: return (ext != 0) ? 4'd6 : 4'd0;
      3'd5: return (ext == 0) ? 4'd0 : (f7[5] ? 4'd8 : 4'd7);
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] m_imm(input logic [6:0] op);
    if (op == SW) return 3'd1;
    if (op == BR) return 3'd2;
    if (op == JL) return 3'd3;
    if (op == LU) return 3'd4;
    return 3'd0;
  endfunction

  function automatic outs_t m_out(input int st, input int ext, input logic [6:0] op,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic zero, input logic mr);
    outs_t o = '0;
    o.st  = 4'(st);
    o.imm = m_imm(op);
    o.ill = (st == 12);
    case (st)
      0:  begin o.sb = 2; o.res = 2; o.pcw = mr; o.irw = mr; end
      1:  begin o.sa = 1; o.sb = 1; end
      2:  begin o.sa = 2; o.sb = 1; end
      3:  o.adr = 1;
      4:  begin o.res = 1; o.regw = 1; end
      5:  begin o.adr = 1; o.memw = 1; end
      6:  begin o.sa = 2; o.alu = m_funct(op, f3, f7, ext); end
      7:  begin o.sa = 2; o.sb = 1; o.alu = m_funct(op, f3, f7, ext); end
      8:  o.regw = 1;
      9:  begin o.sa = 2; o.alu = 1; o.pcw = f3[0] ? ~zero : zero; end
      10: begin o.sa = 1; o.sb = 2; o.pcw = 1; end
      11: begin o.sa = 3; o.sb = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Expected state path of one instruction plus the mem_ready value to drive each cycle
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input int fw, input int dw);
    int k1 = kind(op, f3, 1);
    int k0 = kind(op, f3, 0);
    int tail[$];
    tr0.delete(); tr1.delete(); mrq.delete();
    for (int i = 0; i <= fw; i++) begin
      tr1.push_back(0);
      mrq.push_back(i == fw);
    end
    case (k1)
      1: begin tail = {1, 2}; for (int i = 0; i <= dw; i++) tail.push_back(3); tail.push_back(4); end
      2: begin tail = {1, 2}; for (int i = 0; i <= dw; i++) tail.push_back(5); end
      3: tail = {1, 6, 8};
      4: tail = {1, 7, 8};
      5: tail = {1, 9};
      6: tail = {1, 10, 8};
      7: tail = {1, 11, 8};
      default: tail = {1, 12, 12};
    endcase
    for (int i = 0; i < tail.size(); i++) begin
      tr1.push_back(tail[i]);
      if (tail[i] == 3 || tail[i] == 5) mrq.push_back(i >= tail.size() - 1 || tail[i + 1] != tail[i]);
      else mrq.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < tr1.size(); i++)
      tr0.push_back((k0 == k1) ? tr1[i] : (i <= fw) ? 0 : (i == fw + 1) ? 1 : 12);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Entered and left at posedge+1 with both DUTs in FETCH; zmode 0/1 forces Zero, 2 randomizes
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int dw, input int zmode);
    build(op, f3, fw, dw);
    Op = op; funct3 = f3; funct7 = f7;
    for (int k = 0; k < tr1.size(); k++) begin
      mem_ready = mrq[k];
      Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      e_st[0] = tr0[k];
      e_st[1] = tr1[k];
      chk_en = 1'b1;
      step();
    end
    chk_en = 1'b0;
    if (tr0[tr0.size() - 1] == 12) do_reset();
  endtask

  always @(negedge clk) begin
    outs_t e;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        e = m_out(e_st[d], d, Op, funct3, funct7, Zero, mem_ready);
        tests++;
        if (got[d] !== e) begin
          fails++;
          $display("FAIL cycle_outputs ext%0d t=%0t op=%b f3=%b: got %h, expected %h (state exp %0d got %0d)",
                   d, $time, Op, funct3, got[d], e, e_st[d], got[d].st);
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [8];
    logic [6:0] f7v;
    ops = '{LW, SW, RT, IT, BR, JL, LU, JR};

    #3;
    chk("reset_state0", 32'(state_o[0]), 32'd0);
    chk("reset_state1", 32'(state_o[1]), 32'd0);
    chk("reset_illegal", {31'd0, illegal[0] | illegal[1]}, 32'd0);
    step();
    rst = 1'b1;

    // Pin the model with hand-derived paths and ALU codes
    build(RT, 3'd0, 0, 0);
    chk("model_add_path", tr1.size() == 4 && tr1[1] == 1 && tr1[2] == 6 && tr1[3] == 8, 1);
    build(LW, 3'd2, 0, 3);
    chk("model_lw_path", tr1.size() == 8 && tr1[3] == 3 && tr1[6] == 3 && tr1[7] == 4, 1);
    build(SW, 3'd2, 0, 0);
    chk("model_sw_len", tr1.size(), 4);
    build(BR, 3'd1, 0, 0);
    chk("model_br_len", tr1.size(), 3);
    build(RT, 3'd4, 0, 0);
    chk("model_trap_ext0", tr0[2], 12);
    chk("model_sra_code", m_funct(RT, 3'd5, 7'h20, 1), 4'b1000);

    // Directed instructions
    run_instr(RT, 3'd0, 7'h00, 0, 0, 2);
    run_instr(RT, 3'd0, 7'h20, 0, 0, 2);
    run_instr(LW, 3'd2, 7'h00, 0, 3, 2);
    run_instr(SW, 3'd2, 7'h00, 1, 2, 2);
    run_instr(BR, 3'd0, 7'h00, 0, 0, 1);
    run_instr(BR, 3'd1, 7'h00, 0, 0, 1);
    run_instr(JL, 3'd0, 7'h00, 0, 0, 2);
    run_instr(LU, 3'd0, 7'h00, 0, 0, 2);
    run_instr(IT, 3'd5, 7'h20, 0, 0, 2);

    // xor traps only in the narrow configuration; the trap is sticky
    Op = RT; funct3 = 3'd4; funct7 = 7'h00; mem_ready = 1'b1;
    step(); step();
    chk("trap_state", 32'(state_o[0]), 32'd12);
    chk("trap_illegal", {31'd0, illegal[0]}, 32'd1);
    chk("xor_state_ext1", 32'(state_o[1]), 32'd6);
    chk("xor_alu_ext1", 32'(alu_c1), 32'b0100);
    repeat (3) step();
    chk("trap_held", {27'd0, illegal[0], state_o[0]}, {27'd0, 1'b1, 4'd12});
    do_reset();

    Op = RT; funct3 = 3'd5; funct7 = 7'h20; mem_ready = 1'b1;
    step(); step();
    chk("sra_alu_ext1", 32'(alu_c1), 32'b1000);
    do_reset();

    // Async reset in the middle of a held store
    Op = SW; funct3 = 3'd2; funct7 = 7'h00; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step(); step();
    chk("sw_in_memwrite", {27'd0, mem_write[1], state_o[1]}, {27'd0, 1'b1, 4'd5});
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_state", {28'd0, state_o[0] | state_o[1]}, 32'd0);
    chk("rst_mid_memwrite", {31'd0, mem_write[0] | mem_write[1]}, 32'd0);
    chk("rst_mid_illegal", {31'd0, illegal[0] | illegal[1]}, 32'd0);
    step();
    rst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0: f7v = 7'h00;
        1: f7v = 7'h20;
        default: f7v = 7'($urandom);
      endcase
      run_instr(($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)],
                3'($urandom), f7v, $urandom_range(0, 2), $urandom_range(0, 3), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
